// File: rtl/controle_pkg.sv
// Shared definitions for the cap/bottle dispenser controller: FSM encoding,
// default sizing constants and the pulse-timer width helper.
package controle_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_STOCK = 2'd1,
        DISPENSE   = 2'd2,
        ACK        = 2'd3
    } state_t;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_MAX_STOCK    = 255;
    localparam int DEF_PULSE_CYCLES = 4;
    localparam int DEF_LOW_THRESH   = 5;

    // One spare bit so the timer can always hold PULSE_CYCLES-1.
    function automatic int timer_w(input int pulses);
        return $clog2(pulses) + 1;
    endfunction

endpackage

// File: rtl/estoque_sat.sv
// Stock register: adds refill loads and subtracts one per dispense,
// clipping at MAX_STOCK and flagging a clipped refill for one cycle.
module estoque_sat
    import controle_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_STOCK = DEF_MAX_STOCK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             refill,
    input  logic [WIDTH-1:0] refill_qty,
    input  logic             dec,
    output logic [WIDTH-1:0] stock,
    output logic             overflow
);

    localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MAX_STOCK);

    logic [WIDTH:0] sum;
    logic           clip;

    // dec is only raised with stock >= 1, so the subtraction cannot wrap.
    always_comb begin
        sum  = {1'b0, stock}
             + (refill ? {1'b0, refill_qty} : '0)
             - {{WIDTH{1'b0}}, dec};
        clip = (sum > MAXV);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stock    <= '0;
            overflow <= 1'b0;
        end else begin
            stock    <= clip ? MAXV[WIDTH-1:0] : sum[WIDTH-1:0];
            overflow <= refill && clip;
        end
    end

endmodule

// File: rtl/controle_dispensador.sv
// Dispense controller: four-phase req/ack with the line, fixed-length
// actuator pulse, and stock bookkeeping with low/empty/overflow status.
module controle_dispensador
    import controle_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int MAX_STOCK    = DEF_MAX_STOCK,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int LOW_THRESH   = DEF_LOW_THRESH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    output logic             ack,
    input  logic             refill,
    input  logic [WIDTH-1:0] refill_qty,
    output logic             actuator,
    output logic [WIDTH-1:0] stock,
    output logic             low,
    output logic             empty,
    output logic             busy,
    output logic             overflow
);

    localparam int             TW     = timer_w(PULSE_CYCLES);
    localparam logic [TW-1:0]  T_LOAD = TW'(PULSE_CYCLES - 1);

    state_t        state, nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= nxt;
            timer <= timer_nxt;
        end
    end

    always_comb begin
        nxt       = state;
        timer_nxt = timer;
        dec       = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (stock != '0) begin
                        nxt       = DISPENSE;
                        timer_nxt = T_LOAD;
                    end else begin
                        nxt = WAIT_STOCK;
                    end
                end
            end
            // Arriving stock wins over a simultaneous req drop.
            WAIT_STOCK: begin
                if (stock != '0) begin
                    nxt       = DISPENSE;
                    timer_nxt = T_LOAD;
                end else if (!req) begin
                    nxt = IDLE;
                end
            end
            DISPENSE: begin
                if (timer == '0) begin
                    dec = 1'b1;
                    nxt = ACK;
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            ACK: begin
                if (!req) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    estoque_sat #(
        .WIDTH     (WIDTH),
        .MAX_STOCK (MAX_STOCK)
    ) u_estoque (
        .clk        (clk),
        .reset      (reset),
        .refill     (refill),
        .refill_qty (refill_qty),
        .dec        (dec),
        .stock      (stock),
        .overflow   (overflow)
    );

    // Status is decoded from registers only; no input reaches these outputs.
    assign actuator = (state == DISPENSE);
    assign ack      = (state == ACK);
    assign busy     = (state != IDLE);
    assign empty    = (stock == '0);
    assign low      = (32'(stock) <= LOW_THRESH);

endmodule
